// File: rtl/breath_sequencer.sv
// breath_sequencer
//   Drives the breathing-LED brightness ramp. A prescaler divides clk into
//   step ticks; on each tick an up/down level counter advances through
//   RISE -> HOLD_HIGH -> FALL -> HOLD_LOW and back to RISE.
//
//   Parameters
//     BITS        level width, MAX = 2**BITS-1
//     PRESCALE    clocks per step tick (>= 1)
//     HOLD_STEPS  ticks spent at peak and at trough (0 = no holds)
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous active-high reset, overrides enable
//     enable      1 = sequence runs, 0 = freeze prescaler/level/state/hold
//     level       current brightness level (registered)
//     dir         0 = rising / trough hold, 1 = falling / peak hold
//     state       0 RISE, 1 HOLD_HIGH, 2 FALL, 3 HOLD_LOW
//     cycle_done  one-clock pulse after the tick that starts a new breath
//     pwm         LED drive; generated from level when BREATH_PWM_EN is
//                 defined, otherwise tied to 0
//
//   Optional feature macro: BREATH_PWM_EN
module breath_sequencer #(
  parameter int unsigned BITS       = 4,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned HOLD_STEPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic [BITS-1:0] level,
  output logic            dir,
  output logic [1:0]      state,
  output logic            cycle_done,
  output logic            pwm
);

  localparam int unsigned PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HW    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam bit          HOLDS = (HOLD_STEPS != 0);

  localparam logic [BITS-1:0] MAX       = '1;
  localparam logic [BITS-1:0] MAX_M1    = MAX - 1'b1;
  localparam logic [BITS-1:0] ONE       = BITS'(1);
  localparam logic [PW-1:0]   PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  typedef enum logic [1:0] {
    RISE      = 2'd0,
    HOLD_HIGH = 2'd1,
    FALL      = 2'd2,
    HOLD_LOW  = 2'd3
  } state_t;

  state_t          st;
  logic [PW-1:0]   prescaler;
  logic [HW-1:0]   hold_cnt;
  logic            tick;

  assign tick  = enable && (prescaler == PS_LAST);
  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= RISE;
      level      <= '0;
      dir        <= 1'b0;
      prescaler  <= '0;
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;

      if (enable) begin
        prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      end

      if (tick) begin
        unique case (st)
          RISE: begin
            if (level != MAX) begin
              level <= level + 1'b1;
            end
            if (level == MAX_M1) begin
              dir <= 1'b1;
              st  <= HOLDS ? HOLD_HIGH : FALL;
            end
          end

          HOLD_HIGH: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              st       <= FALL;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          FALL: begin
            if (level != '0) begin
              level <= level - 1'b1;
            end
            if (level == ONE) begin
              dir <= 1'b0;
              if (HOLDS) begin
                st <= HOLD_LOW;
              end else begin
                // Without holds the trough is also the breath boundary.
                st         <= RISE;
                cycle_done <= 1'b1;
              end
            end
          end

          HOLD_LOW: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt   <= '0;
              st         <= RISE;
              cycle_done <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          default: st <= RISE;
        endcase
      end
    end
  end

`ifdef BREATH_PWM_EN
  // Free-running, ungated by enable, so duty tracks level even when frozen.
  logic [BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm     <= (pwm_cnt < level);
    end
  end
`else
  assign pwm = 1'b0;
`endif

endmodule

// File: tb/tb_breath_sequencer.sv
module tb_breath_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: BITS=4, PRESCALE=2, HOLD_STEPS=2
  logic       reset, enable;
  logic [3:0] m_level;
  logic       m_dir, m_done, m_pwm;
  logic [1:0] m_state;

  breath_sequencer #(.BITS(4), .PRESCALE(2), .HOLD_STEPS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .level(m_level), .dir(m_dir),
    .state(m_state), .cycle_done(m_done), .pwm(m_pwm)
  );

  // no-hold instance
  logic       rst0;
  logic [3:0] z_level;
  logic       z_dir, z_done, z_pwm;
  logic [1:0] z_state;

  breath_sequencer #(.BITS(4), .PRESCALE(2), .HOLD_STEPS(0)) dut0 (
    .clk(clk), .reset(rst0), .enable(1'b1), .level(z_level), .dir(z_dir),
    .state(z_state), .cycle_done(z_done), .pwm(z_pwm)
  );

  // slow instance for PWM duty measurement
  logic       rstp;
  logic [3:0] p_level;
  logic       p_dir, p_done, p_pwm;
  logic [1:0] p_state;

  breath_sequencer #(.BITS(4), .PRESCALE(64), .HOLD_STEPS(2)) dutp (
    .clk(clk), .reset(rstp), .enable(1'b1), .level(p_level), .dir(p_dir),
    .state(p_state), .cycle_done(p_done), .pwm(p_pwm)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_main = 0;
  int unsigned pwm_hi_main = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (m_done) done_main++;
      if (m_pwm)  pwm_hi_main++;
    end
  endtask

  typedef struct {
    int unsigned ncyc;
    logic        en;
    logic [3:0]  lvl;
    logic [1:0]  st;
    logic        dir;
    logic        done;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    int unsigned bad_state, z_done_cnt, pwm4, pwm15;

    // clocks advanced with enable, then expected level/state/dir/done
    tbl[0]  = '{1,  1'b1, 4'd0,  2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 4'd1,  2'd0, 1'b0, 1'b0};
    tbl[2]  = '{9,  1'b1, 4'd5,  2'd0, 1'b0, 1'b0};  // odd prescaler phase
    tbl[3]  = '{10, 1'b0, 4'd5,  2'd0, 1'b0, 1'b0};  // frozen
    tbl[4]  = '{10, 1'b0, 4'd5,  2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1,  1'b1, 4'd6,  2'd0, 1'b0, 1'b0};  // phase preserved
    tbl[6]  = '{17, 1'b1, 4'd14, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1,  1'b1, 4'd15, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{3,  1'b1, 4'd15, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1,  1'b1, 4'd15, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{2,  1'b1, 4'd14, 2'd2, 1'b1, 1'b0};
    tbl[11] = '{27, 1'b1, 4'd1,  2'd2, 1'b1, 1'b0};
    tbl[12] = '{1,  1'b1, 4'd0,  2'd3, 1'b0, 1'b0};
    tbl[13] = '{3,  1'b1, 4'd0,  2'd3, 1'b0, 1'b0};
    tbl[14] = '{1,  1'b1, 4'd0,  2'd0, 1'b0, 1'b1};
    tbl[15] = '{1,  1'b1, 4'd0,  2'd0, 1'b0, 1'b0};
    tbl[16] = '{1,  1'b1, 4'd1,  2'd0, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b0; rst0 = 1'b1; rstp = 1'b1;

    // reset with enable low, then high
    step(2);
    chk("rst_level", m_level, 0); chk("rst_dir", m_dir, 0);
    chk("rst_state", m_state, 0); chk("rst_done", m_done, 0);
    chk("rst_pwm", m_pwm, 0);
    enable = 1'b1;
    step(2);
    chk("rst_en_level", m_level, 0); chk("rst_en_dir", m_dir, 0);
    chk("rst_en_state", m_state, 0); chk("rst_en_done", m_done, 0);
    chk("rst_en_pwm", m_pwm, 0);

    // full breath with freeze in RISE
    reset = 1'b0;
    done_main = 0;
    foreach (tbl[k]) begin
      enable = tbl[k].en;
      step(tbl[k].ncyc);
      chk($sformatf("row%0d_level", k), m_level, tbl[k].lvl);
      chk($sformatf("row%0d_state", k), m_state, tbl[k].st);
      chk($sformatf("row%0d_dir",   k), m_dir,   tbl[k].dir);
      chk($sformatf("row%0d_done",  k), m_done,  tbl[k].done);
    end
    chk("breath_done_pulses", done_main, 1);

    // reset in the middle of FALL
    found = 1'b0;
    for (int unsigned i = 0; i < 200 && !found; i++) begin
      step(1);
      if (m_level == 4'd9 && m_state == 2'd2) found = 1'b1;
    end
    chk("midfall_reached", found, 1);
    reset = 1'b1;
    step(1);
    chk("midfall_rst_level", m_level, 0);
    chk("midfall_rst_state", m_state, 0);
    chk("midfall_rst_dir", m_dir, 0);
    reset = 1'b0;
    step(2);
    chk("midfall_restart_level", m_level, 1);
    chk("midfall_restart_state", m_state, 0);

    // HOLD_STEPS=0: no hold states, breath every 60 clocks
    rst0 = 1'b0;
    bad_state = 0; z_done_cnt = 0;
    for (int unsigned i = 1; i <= 120; i++) begin
      step(1);
      if (z_state == 2'd1 || z_state == 2'd3) bad_state++;
      if (z_done) z_done_cnt++;
      if (i == 30) begin
        chk("nohold_peak_level", z_level, 15);
        chk("nohold_peak_state", z_state, 2);
        chk("nohold_peak_dir", z_dir, 1);
      end
      if (i == 32) begin
        chk("nohold_fall_level", z_level, 14);
        chk("nohold_fall_state", z_state, 2);
      end
      if (i == 60) begin
        chk("nohold_done_60", z_done, 1);
        chk("nohold_trough_level", z_level, 0);
        chk("nohold_trough_state", z_state, 0);
      end
      if (i == 61) chk("nohold_done_61", z_done, 0);
      if (i == 120) chk("nohold_done_120", z_done, 1);
    end
    chk("nohold_bad_states", bad_state, 0);
    chk("nohold_done_count", z_done_cnt, 2);

    // PWM duty at level 4 and level 15
    rstp = 1'b0;
    pwm4 = 0; pwm15 = 0;
    for (int unsigned i = 1; i <= 1020; i++) begin
      step(1);
      if (i == 270)  chk("pwm_level4", p_level, 4);
      if (i == 1000) chk("pwm_level15", p_level, 15);
      if (i >= 270 && i <= 285 && p_pwm) pwm4++;
      if (i >= 1000 && i <= 1015 && p_pwm) pwm15++;
    end
`ifdef BREATH_PWM_EN
    chk("pwm_duty_l4", pwm4, 4);
    chk("pwm_duty_l15", pwm15, 15);
`else
    chk("pwm_off_l4", pwm4, 0);
    chk("pwm_off_l15", pwm15, 0);
    chk("pwm_off_main", pwm_hi_main, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
